// File: rtl/gc_pkg.sv
// Shared types and limits for Gray-code counter consumers.
package gc_pkg;

   localparam int unsigned ERR_CNT_W   = 8;
   localparam int unsigned ERR_CNT_MAX = 255;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SUSPECT  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      UP   = 2'd0,
      DOWN = 2'd1,
      HOLD = 2'd2,
      ERR  = 2'd3
   } step_t;

endpackage : gc_pkg

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; bit i is the XOR of all Gray bits at or above i.
module gray2bin #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^(gray >> i);
   end

endmodule : gray2bin

// File: rtl/gc_decoder.sv
// Gray-coded count receiver: decodes, classifies each step against the last
// accepted sample and tracks lock status plus a saturating error count.
module gc_decoder
   import gc_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid,
   input  logic [WIDTH-1:0]     gray,
   output logic [WIDTH-1:0]     bin,
   output logic                 out_valid,
   output logic                 dir,
   output logic                 step_err,
   output logic                 sync,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [WIDTH-1:0]     DIFF_UP   = WIDTH'(1);
   localparam logic [WIDTH-1:0]     DIFF_DOWN = '1;
   localparam logic [WIDTH-1:0]     DIFF_HOLD = '0;
   localparam logic [ERR_CNT_W-1:0] CNT_MAX   = ERR_CNT_W'(ERR_CNT_MAX);

   state_t                 state, state_d;
   step_t                  step_cls;
   logic [WIDTH-1:0]       new_bin;
   logic [WIDTH-1:0]       diff;
   logic [WIDTH-1:0]       bin_d;
   logic                   dir_d;
   logic                   out_valid_d;
   logic                   step_err_d;
   logic                   sync_d;
   logic [ERR_CNT_W-1:0]   err_cnt_d;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (gray),
      .bin  (new_bin)
   );

   // bin doubles as the reference value for step classification
   always_comb begin
      diff = WIDTH'(new_bin - bin);
      if (diff == DIFF_UP)        step_cls = UP;
      else if (diff == DIFF_DOWN) step_cls = DOWN;
      else if (diff == DIFF_HOLD) step_cls = HOLD;
      else                        step_cls = ERR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= UNLOCKED;
         bin       <= '0;
         dir       <= 1'b1;
         out_valid <= 1'b0;
         step_err  <= 1'b0;
         sync      <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_d;
         bin       <= bin_d;
         dir       <= dir_d;
         out_valid <= out_valid_d;
         step_err  <= step_err_d;
         sync      <= sync_d;
         err_cnt   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      bin_d       = bin;
      dir_d       = dir;
      out_valid_d = 1'b0;
      step_err_d  = 1'b0;
      err_cnt_d   = err_cnt;

      if (valid) begin
         out_valid_d = 1'b1;
         bin_d       = new_bin;

         // The first sample after unlock only seeds the reference
         if (state != UNLOCKED) begin
            if (step_cls == UP)   dir_d = 1'b1;
            if (step_cls == DOWN) dir_d = 1'b0;
            if (step_cls == ERR) begin
               step_err_d = 1'b1;
               if (err_cnt != CNT_MAX) err_cnt_d = err_cnt + ERR_CNT_W'(1);
            end
         end

         case (state)
            UNLOCKED: state_d = SUSPECT;
            SUSPECT: begin
               if (step_cls == UP || step_cls == DOWN) state_d = LOCKED;
               else if (step_cls == ERR)               state_d = UNLOCKED;
            end
            LOCKED: begin
               if (step_cls == ERR) state_d = SUSPECT;
            end
            default: state_d = UNLOCKED;
         endcase
      end

      sync_d = (state_d == LOCKED);
   end

endmodule : gc_decoder

// File: tb/tb_gc_decoder.sv
// Directed self-checking bench for gc_decoder (WIDTH = 3).
module tb_gc_decoder;

   localparam int unsigned W = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid;
   logic [W-1:0] gray;
   logic [W-1:0] bin;
   logic         out_valid;
   logic         dir;
   logic         step_err;
   logic         sync;
   logic [7:0]   err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   gc_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .gray      (gray),
      .bin       (bin),
      .out_valid (out_valid),
      .dir       (dir),
      .step_err  (step_err),
      .sync      (sync),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] e_bin, input logic e_ov,
                          input logic e_dir, input logic e_err, input logic e_sync,
                          input logic [7:0] e_cnt);
      check_eq({tag, "_bin"},  32'(bin),       32'(e_bin));
      check_eq({tag, "_ov"},   32'(out_valid), 32'(e_ov));
      check_eq({tag, "_dir"},  32'(dir),       32'(e_dir));
      check_eq({tag, "_err"},  32'(step_err),  32'(e_err));
      check_eq({tag, "_sync"}, 32'(sync),      32'(e_sync));
      check_eq({tag, "_cnt"},  32'(err_cnt),   32'(e_cnt));
   endtask

   task automatic step(input logic v, input logic [W-1:0] g);
      @(negedge clk);
      valid = v;
      gray  = g;
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] up_gray [9];
   logic [W-1:0] g;
   logic         e;
   logic [7:0]   exp_cnt;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      up_gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

      // Reset with random stimulus
      reset = 1'b0;
      valid = 1'b0;
      gray  = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid = 1'($urandom_range(1));
         gray  = W'($urandom_range(7));
      end
      @(posedge clk);
      #1;
      chk_out("rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      valid = 1'b0;
      reset = 1'b1;

      // Up sequence with wrap
      for (int i = 0; i < 9; i++) begin
         step(1'b1, up_gray[i]);
         chk_out($sformatf("up%0d", i), W'(i % 8), 1'b1, 1'b1, 1'b0, (i >= 1), 8'd0);
      end

      // Down, hold, idle
      step(1'b1, 3'b100);
      chk_out("down", 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
      step(1'b1, 3'b100);
      chk_out("hold", 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'b011);
         chk_out($sformatf("idle%0d", i), 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      end

      // Climb to bin 2, then glitch recovery
      step(1'b1, 3'b000);
      step(1'b1, 3'b001);
      step(1'b1, 3'b011);
      chk_out("at2", 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
      step(1'b1, 3'b101);
      chk_out("glitch", 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
      step(1'b1, 3'b100);
      chk_out("relock1", 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
      step(1'b1, 3'b010);
      chk_out("bad1", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
      step(1'b1, 3'b100);
      chk_out("bad2", 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
      // Unlocked: a jump is accepted unchecked
      step(1'b1, 3'b011);
      chk_out("seed", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
      step(1'b1, 3'b010);
      chk_out("relock2", 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);

      // Saturation: bin 0 / bin 4 alternating from LOCKED at 3
      exp_cnt = 8'd3;
      for (int i = 0; i < 600; i++) begin
         g = (i % 2 == 0) ? 3'b000 : 3'b110;
         step(1'b1, g);
         e = (i < 2) || (i % 2 == 1);
         if (e && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
         check_eq($sformatf("sat_err%0d", i), 32'(step_err), 32'(e));
         check_eq($sformatf("sat_cnt%0d", i), 32'(err_cnt), 32'(exp_cnt));
      end
      check_eq("sat_final", 32'(err_cnt), 32'd255);

      // Lock at bin 5, then async reset between edges
      step(1'b1, 3'b110);
      step(1'b1, 3'b111);
      chk_out("at5", 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'd255);
      #2;
      reset = 1'b0;
      #1;
      chk_out("midrst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      valid = 1'b0;
      reset = 1'b1;
      step(1'b1, 3'b010);
      chk_out("post1", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 3'b110);
      chk_out("post2", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_gc_decoder
